// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm engine.
package alarm_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int CNT_W  = 12;

    typedef enum logic [1:0] {
        ALM_IDLE    = 2'd0,
        ALM_RINGING = 2'd1,
        ALM_SNOOZED = 2'd2
    } alarm_state_e;

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored alarm time, ring/snooze FSM, ring and snooze counters,
// and a sticky missed flag set when ringing times out unattended.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              i_tick,
    input  logic [HOUR_W-1:0] i_cur_hours,
    input  logic [MIN_W-1:0]  i_cur_minutes,
    input  logic [SEC_W-1:0]  i_cur_seconds,
    input  logic              i_wr,
    input  logic [HOUR_W-1:0] i_wr_hours,
    input  logic [MIN_W-1:0]  i_wr_minutes,
    input  logic              i_wr_enable,
    input  logic              i_snooze,
    input  logic              i_off,
    input  logic              i_missed_clr,
    output alarm_state_e      o_state,
    output logic              o_missed
);

    localparam logic [CNT_W-1:0] L_SNOOZE  = CNT_W'(SNOOZE_SEC);
    localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(RING_TIMEOUT_SEC);

    logic [HOUR_W-1:0] r_hours;
    logic [MIN_W-1:0]  r_minutes;
    logic              r_enable;
    alarm_state_e      r_state;
    logic [CNT_W-1:0]  r_ring_cnt;
    logic [CNT_W-1:0]  r_snz_cnt;
    logic              r_missed;

    logic [CNT_W-1:0]  w_ring_next;
    logic              w_match;
    logic              w_timeout;

    // Start of a matching minute on an enabled channel.
    assign w_match = i_tick && (i_cur_seconds == '0) && r_enable &&
                     (i_cur_hours == r_hours) && (i_cur_minutes == r_minutes);

    assign w_ring_next = r_ring_cnt + CNT_W'(1);

    // Unattended ringing expires on this tick; any higher-priority event cancels it.
    assign w_timeout = i_tick && (r_state == ALM_RINGING) && !i_wr && r_enable &&
                       !i_off && !i_snooze && (w_ring_next >= L_TIMEOUT);

    // Alarm register: loaded only by a write to this channel.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hours   <= '0;
            r_minutes <= '0;
            r_enable  <= 1'b0;
        end else if (i_wr) begin
            r_hours   <= i_wr_hours;
            r_minutes <= i_wr_minutes;
            r_enable  <= i_wr_enable;
        end
    end

    // Channel FSM; write/disable beats off, off beats snooze, snooze beats tick events.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ALM_IDLE;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
        end else if (i_wr || !r_enable || i_off) begin
            r_state <= ALM_IDLE;
        end else begin
            case (r_state)
                ALM_IDLE: begin
                    if (w_match) begin
                        r_state    <= ALM_RINGING;
                        r_ring_cnt <= '0;
                    end
                end
                ALM_RINGING: begin
                    if (i_snooze) begin
                        r_state   <= ALM_SNOOZED;
                        r_snz_cnt <= L_SNOOZE;
                    end else if (w_timeout) begin
                        r_state <= ALM_IDLE;
                    end else if (i_tick) begin
                        r_ring_cnt <= w_ring_next;
                    end
                end
                ALM_SNOOZED: begin
                    if (i_tick) begin
                        if (r_snz_cnt == CNT_W'(1)) begin
                            r_state    <= ALM_RINGING;
                            r_ring_cnt <= '0;
                        end else begin
                            r_snz_cnt <= r_snz_cnt - CNT_W'(1);
                        end
                    end
                end
                default: r_state <= ALM_IDLE;
            endcase
        end
    end

    // Missed flag: write clears, timeout sets (and wins over a same-cycle clear).
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_missed <= 1'b0;
        end else if (i_wr) begin
            r_missed <= 1'b0;
        end else if (w_timeout) begin
            r_missed <= 1'b1;
        end else if (i_missed_clr) begin
            r_missed <= 1'b0;
        end
    end

    assign o_state  = r_state;
    assign o_missed = r_missed;

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm engine: write decode into NUM_ALARMS channels, ring OR
// reduction and a lowest-index priority encoder for the buzzer/display side.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS       = 4,
    parameter int SNOOZE_SEC       = 300,
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int IDX_W            = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  clk_1hz_en,
    input  logic [HOUR_W-1:0]     cur_hours,
    input  logic [MIN_W-1:0]      cur_minutes,
    input  logic [SEC_W-1:0]      cur_seconds,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [HOUR_W-1:0]     wr_hours,
    input  logic [MIN_W-1:0]      wr_minutes,
    input  logic                  wr_enable,
    input  logic                  snooze_btn,
    input  logic                  off_btn,
    input  logic                  missed_clr,
    output logic                  ring_out,
    output logic [IDX_W-1:0]      ring_idx,
    output logic [NUM_ALARMS-1:0] ring_vec,
    output logic [NUM_ALARMS-1:0] snooze_vec,
    output logic [NUM_ALARMS-1:0] missed_vec
);

    logic [NUM_ALARMS-1:0] w_wr_sel;
    alarm_state_e          w_state [NUM_ALARMS];

    genvar g;
    generate
        for (g = 0; g < NUM_ALARMS; g++) begin : g_ch
            // Out-of-range indices match no channel and are dropped.
            assign w_wr_sel[g] = wr_en && (wr_idx == IDX_W'(g));

            alarm_channel #(
                .SNOOZE_SEC       (SNOOZE_SEC),
                .RING_TIMEOUT_SEC (RING_TIMEOUT_SEC)
            ) u_ch (
                .sys_clk       (sys_clk),
                .rst_n         (rst_n),
                .i_tick        (clk_1hz_en),
                .i_cur_hours   (cur_hours),
                .i_cur_minutes (cur_minutes),
                .i_cur_seconds (cur_seconds),
                .i_wr          (w_wr_sel[g]),
                .i_wr_hours    (wr_hours),
                .i_wr_minutes  (wr_minutes),
                .i_wr_enable   (wr_enable),
                .i_snooze      (snooze_btn),
                .i_off         (off_btn),
                .i_missed_clr  (missed_clr),
                .o_state       (w_state[g]),
                .o_missed      (missed_vec[g])
            );

            assign ring_vec[g]   = (w_state[g] == ALM_RINGING);
            assign snooze_vec[g] = (w_state[g] == ALM_SNOOZED);
        end
    endgenerate

    assign ring_out = |ring_vec;

    // Lowest-index ringing channel wins; 0 when nothing rings.
    always_comb begin
        ring_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ring_vec[i]) ring_idx = IDX_W'(i);
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Directed, table-driven bench for alarm_bank (4 channels, 300 s snooze, 60 s timeout).
module tb_alarm_bank;

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       clk_1hz_en;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [5:0] cur_seconds;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [4:0] wr_hours;
    logic [5:0] wr_minutes;
    logic       wr_enable;
    logic       snooze_btn;
    logic       off_btn;
    logic       missed_clr;
    logic       ring_out;
    logic [1:0] ring_idx;
    logic [3:0] ring_vec;
    logic [3:0] snooze_vec;
    logic [3:0] missed_vec;

    always #5 sys_clk = ~sys_clk;

    alarm_bank #(
        .NUM_ALARMS       (4),
        .SNOOZE_SEC       (300),
        .RING_TIMEOUT_SEC (60)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .clk_1hz_en  (clk_1hz_en),
        .cur_hours   (cur_hours),
        .cur_minutes (cur_minutes),
        .cur_seconds (cur_seconds),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_hours    (wr_hours),
        .wr_minutes  (wr_minutes),
        .wr_enable   (wr_enable),
        .snooze_btn  (snooze_btn),
        .off_btn     (off_btn),
        .missed_clr  (missed_clr),
        .ring_out    (ring_out),
        .ring_idx    (ring_idx),
        .ring_vec    (ring_vec),
        .snooze_vec  (snooze_vec),
        .missed_vec  (missed_vec)
    );

    typedef struct {
        logic       wr_en;
        logic [1:0] wr_idx;
        logic [4:0] wr_h;
        logic [5:0] wr_m;
        logic       wr_enable;
        logic       snooze;
        logic       off;
        logic       mclr;
        logic       tick;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       e_ring;
        logic [1:0] e_idx;
        logic [3:0] e_rvec;
        logic [3:0] e_svec;
        logic [3:0] e_mvec;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Write vector: no tick, no buttons.
    function automatic vec_t wr(input logic [1:0] idx, input int h, input int m, input logic en,
                                input logic er, input logic [1:0] ei,
                                input logic [3:0] erv, input logic [3:0] esv, input logic [3:0] emv);
        vec_t x;
        x.wr_en = 1'b1; x.wr_idx = idx; x.wr_h = 5'(h); x.wr_m = 6'(m); x.wr_enable = en;
        x.snooze = 1'b0; x.off = 1'b0; x.mclr = 1'b0; x.tick = 1'b0;
        x.h = 5'd0; x.m = 6'd0; x.s = 6'd1;
        x.e_ring = er; x.e_idx = ei; x.e_rvec = erv; x.e_svec = esv; x.e_mvec = emv;
        return x;
    endfunction

    // Tick vector with optional buttons in the same cycle.
    function automatic vec_t tk(input int h, input int m, input int s,
                                input logic sn, input logic off, input logic mc,
                                input logic er, input logic [1:0] ei,
                                input logic [3:0] erv, input logic [3:0] esv, input logic [3:0] emv);
        vec_t x;
        x.wr_en = 1'b0; x.wr_idx = 2'd0; x.wr_h = 5'd0; x.wr_m = 6'd0; x.wr_enable = 1'b0;
        x.snooze = sn; x.off = off; x.mclr = mc; x.tick = 1'b1;
        x.h = 5'(h); x.m = 6'(m); x.s = 6'(s);
        x.e_ring = er; x.e_idx = ei; x.e_rvec = erv; x.e_svec = esv; x.e_mvec = emv;
        return x;
    endfunction

    // Button-only vector between ticks.
    function automatic vec_t btn(input logic sn, input logic off, input logic mc,
                                 input logic er, input logic [1:0] ei,
                                 input logic [3:0] erv, input logic [3:0] esv, input logic [3:0] emv);
        vec_t x;
        x = tk(0, 0, 1, sn, off, mc, er, ei, erv, esv, emv);
        x.tick = 1'b0;
        return x;
    endfunction

    task automatic idle_inputs();
        clk_1hz_en = 1'b0; cur_hours = 5'd0; cur_minutes = 6'd0; cur_seconds = 6'd1;
        wr_en = 1'b0; wr_idx = 2'd0; wr_hours = 5'd0; wr_minutes = 6'd0; wr_enable = 1'b0;
        snooze_btn = 1'b0; off_btn = 1'b0; missed_clr = 1'b0;
    endtask

    task automatic check(input string name, input int tag, input logic er, input logic [1:0] ei,
                         input logic [3:0] erv, input logic [3:0] esv, input logic [3:0] emv);
        n_vec++;
        if ({ring_out, ring_idx, ring_vec, snooze_vec, missed_vec} !== {er, ei, erv, esv, emv}) begin
            n_err++;
            $display("FAIL %s[%0d]: got ring=%b idx=%0d rvec=%b svec=%b mvec=%b, want ring=%b idx=%0d rvec=%b svec=%b mvec=%b",
                     name, tag, ring_out, ring_idx, ring_vec, snooze_vec, missed_vec, er, ei, erv, esv, emv);
        end
    endtask

    // Drive one vector for one sys_clk, then compare just after the edge.
    task automatic apply_vec(input vec_t x, input string name, input int tag);
        wr_en = x.wr_en; wr_idx = x.wr_idx; wr_hours = x.wr_h; wr_minutes = x.wr_m; wr_enable = x.wr_enable;
        snooze_btn = x.snooze; off_btn = x.off; missed_clr = x.mclr; clk_1hz_en = x.tick;
        cur_hours = x.h; cur_minutes = x.m; cur_seconds = x.s;
        @(posedge sys_clk);
        #1;
        idle_inputs();
        check(name, tag, x.e_ring, x.e_idx, x.e_rvec, x.e_svec, x.e_mvec);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) apply_vec(tbl[i], name, i);
        tbl.delete();
    endtask

    // Consecutive 1 Hz ticks over [t0,t1] seconds-of-day, all with one expectation.
    task automatic run_ticks(input string name, input int t0, input int t1,
                             input logic er, input logic [1:0] ei,
                             input logic [3:0] erv, input logic [3:0] esv, input logic [3:0] emv);
        for (int t = t0; t <= t1; t++) begin
            apply_vec(tk(t / 3600, (t / 60) % 60, t % 60, 1'b0, 1'b0, 1'b0, er, ei, erv, esv, emv), name, t);
        end
    endtask

    function automatic int hms(input int h, input int m, input int s);
        return h * 3600 + m * 60 + s;
    endfunction

    initial begin
        // Clock/reset
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("reset_async", 0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000);
        repeat (2) @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        check("reset_release", 0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000);

        // ch0 07:30: ring on the :00 tick, off, no re-trigger later in the minute
        tbl.push_back(wr(2'd0, 7, 30, 1'b1,          1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(7, 29, 58, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(7, 29, 59, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(7, 30, 0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(btn(1'b0, 1'b0, 1'b0,           1'b1, 2'd0, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(btn(1'b0, 1'b1, 1'b0,           1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(7, 30, 1,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(7, 30, 2,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        // ch1 06:00 rings
        tbl.push_back(wr(2'd1, 6, 0, 1'b1,           1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(6, 0, 0,   1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000, 4'b0000));
        run_table("ch0_ch1");

        // ch1 snooze at 06:00:05, second press ignored, re-ring at 06:05:05, off
        run_ticks("ch1_ring", hms(6, 0, 1), hms(6, 0, 5), 1'b1, 2'd1, 4'b0010, 4'b0000, 4'b0000);
        apply_vec(btn(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0010, 4'b0000), "snooze_press", 0);
        run_ticks("snoozed_a", hms(6, 0, 6), hms(6, 1, 59), 1'b0, 2'd0, 4'b0000, 4'b0010, 4'b0000);
        apply_vec(btn(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0010, 4'b0000), "snooze_again", 0);
        run_ticks("snoozed_b", hms(6, 2, 0), hms(6, 5, 4), 1'b0, 2'd0, 4'b0000, 4'b0010, 4'b0000);
        apply_vec(tk(6, 5, 5, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0000, 4'b0000), "re_ring", 0);
        apply_vec(btn(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000), "off_after_snooze", 0);

        // ch2 08:00 times out at 08:01:00; timeout set beats a same-cycle clear
        tbl.push_back(wr(2'd2, 8, 0, 1'b1,           1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(8, 0, 0,   1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 4'b0000));
        run_table("ch2_start");
        run_ticks("ch2_ringing", hms(8, 0, 1), hms(8, 0, 59), 1'b1, 2'd2, 4'b0100, 4'b0000, 4'b0000);
        tbl.push_back(tk(8, 1, 0,   1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0100));
        tbl.push_back(btn(1'b0, 1'b0, 1'b0,           1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0100));
        tbl.push_back(btn(1'b0, 1'b0, 1'b1,           1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        run_table("ch2_timeout");

        // ch1+ch3 at 09:15, priority index, single off; off on match tick; disable while ringing
        tbl.push_back(wr(2'd1, 9, 15, 1'b1,          1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(wr(2'd3, 9, 15, 1'b1,          1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(9, 15, 0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1010, 4'b0000, 4'b0000));
        tbl.push_back(btn(1'b0, 1'b1, 1'b0,           1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(wr(2'd0, 10, 0, 1'b1,          1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(10, 0, 0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(10, 0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(wr(2'd2, 11, 0, 1'b1,          1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(11, 0, 0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0000, 4'b0000));
        tbl.push_back(wr(2'd2, 11, 0, 1'b0,          1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(wr(2'd3, 13, 0, 1'b1,          1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(13, 0, 0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000, 4'b0000, 4'b0000));
        tbl.push_back(btn(1'b1, 1'b0, 1'b0,           1'b0, 2'd0, 4'b0000, 4'b1000, 4'b0000));
        tbl.push_back(btn(1'b0, 1'b1, 1'b0,           1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        // ch0 12:00 snoozed before the mid-run reset
        tbl.push_back(wr(2'd0, 12, 0, 1'b1,          1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(12, 0, 0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0000, 4'b0000));
        tbl.push_back(btn(1'b1, 1'b0, 1'b0,           1'b0, 2'd0, 4'b0000, 4'b0001, 4'b0000));
        run_table("multi_edges");

        // Reset mid-snooze: everything clears, stored alarms are 00:00 disabled
        rst_n = 1'b0;
        #1;
        check("reset_mid_snooze", 0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000);
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        tbl.push_back(tk(0, 0, 0,   1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        tbl.push_back(tk(9, 15, 0,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000));
        run_table("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
